// File: rtl/s2p_pkg.sv
// Shared types and helpers for the s2p serial link receiver.
// Optional parity support is selected with the S2P_PARITY_EN macro.
package s2p_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    // Bit counter width: must hold the value WIDTH.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    // Even-parity bit for a zero-extended data word, shared with the transmitter.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/s2p_shift_reg.sv
// MSB-first shift register: first bit enters at the LSB and migrates up as later bits arrive.
module s2p_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_first,
    input  logic             shift,
    input  logic             clear,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Truncating casts keep this legal down to a single-bit register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load_first) begin
            q <= WIDTH'(din);
        end else if (shift) begin
            q <= WIDTH'({q, din});
        end
    end

endmodule

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver for the sync-framed single-wire link (MSB first).
// Define S2P_PARITY_EN to add a trailing even-parity bit per frame.
module s2p_rx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync,
    input  logic             sdata,
    output logic [WIDTH-1:0] pdata,
    output logic             pvalid,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err
);
    import s2p_pkg::*;

    localparam int unsigned CW = cnt_w(WIDTH);
`ifdef S2P_PARITY_EN
    // The full word must be held while the parity bit is sampled.
    localparam int unsigned SR_W = WIDTH;
`else
    // Bit 0 is taken straight from sdata on the completing edge.
    localparam int unsigned SR_W = WIDTH - 1;
`endif

    state_t          state, next_state;
    logic [CW-1:0]   cnt, cnt_d;
    logic            sr_load, sr_shift, sr_clear;
    logic [SR_W-1:0] sr_q;
    logic [WIDTH-1:0] word_c;
    logic            pvalid_d, ferr_d, perr_d, busy_d;

    s2p_shift_reg #(.WIDTH(SR_W)) u_shift_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_first (sr_load),
        .shift      (sr_shift),
        .clear      (sr_clear),
        .din        (sdata),
        .q          (sr_q)
    );

`ifdef S2P_PARITY_EN
    assign word_c = sr_q;
`else
    assign word_c = {sr_q, sdata};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_clear   = 1'b0;
        pvalid_d   = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
        busy_d     = 1'b0;
        case (state)
            IDLE: begin
                if (sync) begin
                    sr_load    = 1'b1;
                    cnt_d      = CW'(1);
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (sync) begin
                    // Early sync: drop the partial word and restart on this bit.
                    ferr_d  = 1'b1;
                    sr_load = 1'b1;
                    cnt_d   = CW'(1);
                end else if (cnt == CW'(WIDTH - 1)) begin
`ifdef S2P_PARITY_EN
                    sr_shift   = 1'b1;
                    cnt_d      = CW'(WIDTH);
                    next_state = PAR;
`else
                    pvalid_d   = 1'b1;
                    sr_clear   = 1'b1;
                    cnt_d      = '0;
                    next_state = IDLE;
`endif
                end else begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt + CW'(1);
                end
            end
`ifdef S2P_PARITY_EN
            PAR: begin
                if (sync) begin
                    ferr_d     = 1'b1;
                    sr_load    = 1'b1;
                    cnt_d      = CW'(1);
                    next_state = SHIFT;
                end else begin
                    pvalid_d   = 1'b1;
                    perr_d     = even_parity(32'(sr_q)) ^ sdata;
                    sr_clear   = 1'b1;
                    cnt_d      = '0;
                    next_state = IDLE;
                end
            end
`endif
            default: begin
                next_state = IDLE;
                cnt_d      = '0;
            end
        endcase
        // busy also covers the delivery cycle so it spans the whole frame.
        busy_d = (next_state != IDLE) || pvalid_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pdata      <= '0;
            pvalid     <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            pvalid     <= pvalid_d;
            busy       <= busy_d;
            frame_err  <= ferr_d;
            parity_err <= perr_d;
            if (pvalid_d) begin
                pdata <= word_c;
            end
        end
    end

endmodule

// File: tb/tb_s2p_rx.sv
// Bench for s2p_rx: frame-level model compared every cycle plus directed literal checks.
module tb_s2p_rx;

    localparam int unsigned WIDTH = 8;
`ifdef S2P_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             sync;
    logic             sdata;
    logic [WIDTH-1:0] pdata;
    logic             pvalid, busy, frame_err, parity_err;

    s2p_rx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync       (sync),
        .sdata      (sdata),
        .pdata      (pdata),
        .pvalid     (pvalid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit checking    = 1'b0;

    always @(posedge clk) cyc++;

    // Frame-level model: a list of received bits folded into an integer word.
    bit               m_in_frame = 1'b0;
    int               m_bits     = 0;
    logic [31:0]      m_word     = '0;
    logic [WIDTH-1:0] exp_pdata  = '0;
    logic             exp_pvalid = 1'b0;
    logic             exp_ferr   = 1'b0;
    logic             exp_perr   = 1'b0;
    logic             exp_busy   = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_in_frame = 1'b0;
            m_bits     = 0;
            m_word     = '0;
            exp_pdata  = '0;
            exp_pvalid = 1'b0;
            exp_ferr   = 1'b0;
            exp_perr   = 1'b0;
        end else begin
            exp_pvalid = 1'b0;
            exp_ferr   = 1'b0;
            exp_perr   = 1'b0;
            if (sync) begin
                if (m_in_frame) exp_ferr = 1'b1;
                m_in_frame = 1'b1;
                m_word     = 32'(sdata);
                m_bits     = 1;
            end else if (m_in_frame) begin
                if (m_bits < int'(WIDTH)) begin
                    m_word = (m_word << 1) | 32'(sdata);
                    m_bits++;
`ifndef S2P_PARITY_EN
                    if (m_bits == int'(WIDTH)) begin
                        exp_pdata  = m_word[WIDTH-1:0];
                        exp_pvalid = 1'b1;
                        m_in_frame = 1'b0;
                    end
`endif
                end else begin
                    exp_perr   = (^m_word[WIDTH-1:0]) ^ sdata;
                    exp_pdata  = m_word[WIDTH-1:0];
                    exp_pvalid = 1'b1;
                    m_in_frame = 1'b0;
                end
            end
        end
        exp_busy = m_in_frame || exp_pvalid;
    end

    always @(negedge clk) begin
        if (checking) begin
            vectors++;
            if ({pdata, pvalid, busy, frame_err, parity_err} !==
                {exp_pdata, exp_pvalid, exp_busy, exp_ferr, exp_perr}) begin
                miscompares++;
                $display("FAIL cycle_cmp @%0d: got pdata=%h pvalid=%b busy=%b ferr=%b perr=%b, want pdata=%h pvalid=%b busy=%b ferr=%b perr=%b",
                         cyc, pdata, pvalid, busy, frame_err, parity_err,
                         exp_pdata, exp_pvalid, exp_busy, exp_ferr, exp_perr);
            end
        end
    end

    // Event log used by the directed checks.
    int               pv_cyc[$];
    logic [WIDTH-1:0] pv_dat[$];
    logic             pv_perr[$];
    int               fe_cyc[$];
    int               busy_cnt = 0;

    always @(negedge clk) begin
        if (pvalid) begin
            pv_cyc.push_back(cyc);
            pv_dat.push_back(pdata);
            pv_perr.push_back(parity_err);
        end
        if (frame_err) fe_cyc.push_back(cyc);
        if (busy) busy_cnt++;
    end

    task automatic clr_log();
        pv_cyc.delete();
        pv_dat.delete();
        pv_perr.delete();
        fe_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic d);
        @(posedge clk);
        #1;
        sync  = s;
        sdata = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic pbit, output int t0);
        logic [WIDTH-1:0] wv;
        wv = w;
        t0 = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            drive(i == 0, wv[WIDTH-1-i]);
            if (i == 0) t0 = cyc;
        end
`ifdef S2P_PARITY_EN
        drive(1'b0, pbit);
`else
        if (pbit) t0 = t0;
`endif
    endtask

    int t0, t1;

    initial begin
        reset_n = 1'b0;
        sync    = 1'b0;
        sdata   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pdata",  32'(pdata), 32'h0);
        check("reset_pvalid", 32'(pvalid), 32'h0);
        check("reset_busy",   32'(busy), 32'h0);
        check("reset_ferr",   32'(frame_err), 32'h0);
        check("reset_perr",   32'(parity_err), 32'h0);
        checking = 1'b1;
        reset_n  = 1'b1;

        // Idle noise: sdata toggles with sync low.
        clr_log();
        for (int i = 0; i < 20; i++) drive(1'b0, i[0]);
        idle(1);
        check("noise_no_pvalid", 32'(pv_cyc.size()), 32'd0);
        check("noise_busy_cnt",  32'(busy_cnt), 32'd0);
        check("noise_pdata",     32'(pdata), 32'h0);

        // Single frame 0xA5.
        clr_log();
        send_frame(8'hA5, 1'b0, t0);
        idle(3);
        check("a5_count",    32'(pv_cyc.size()), 32'd1);
        if (pv_cyc.size() > 0) begin
            check("a5_cycle", 32'(pv_cyc[0] - t0), 32'(FL));
            check("a5_data",  32'(pv_dat[0]), 32'hA5);
        end
        check("a5_busy_cnt", 32'(busy_cnt), 32'(FL));
        check("a5_no_ferr",  32'(fe_cyc.size()), 32'd0);

        // Back-to-back 0x3C then 0xFF.
        clr_log();
        send_frame(8'h3C, 1'b0, t0);
        send_frame(8'hFF, 1'b0, t1);
        idle(3);
        check("b2b_count", 32'(pv_cyc.size()), 32'd2);
        if (pv_cyc.size() > 1) begin
            check("b2b_cycle0", 32'(pv_cyc[0] - t0), 32'(FL));
            check("b2b_cycle1", 32'(pv_cyc[1] - t0), 32'(2 * FL));
            check("b2b_data0",  32'(pv_dat[0]), 32'h3C);
            check("b2b_data1",  32'(pv_dat[1]), 32'hFF);
        end
        check("b2b_no_ferr", 32'(fe_cyc.size()), 32'd0);

        // Early sync in cycle 4, then frame 0x81.
        clr_log();
        drive(1'b1, 1'b1);
        t0 = cyc;
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        send_frame(8'h81, 1'b0, t1);
        idle(3);
        check("early_ferr_count", 32'(fe_cyc.size()), 32'd1);
        if (fe_cyc.size() > 0) check("early_ferr_cycle", 32'(fe_cyc[0] - t0), 32'd5);
        check("early_pv_count", 32'(pv_cyc.size()), 32'd1);
        if (pv_cyc.size() > 0) begin
            check("early_pv_cycle", 32'(pv_cyc[0] - t0), 32'(4 + FL));
            check("early_pv_data",  32'(pv_dat[0]), 32'h81);
        end

        // Reset in cycle 3 of a frame, then frame 0x5A.
        clr_log();
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sync    = 1'b0;
        #1;
        check("midrst_pdata",  32'(pdata), 32'h0);
        check("midrst_pvalid", 32'(pvalid), 32'h0);
        check("midrst_busy",   32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(FL + 2);
        check("midrst_no_pvalid", 32'(pv_cyc.size()), 32'd0);
        check("midrst_no_ferr",   32'(fe_cyc.size()), 32'd0);
        clr_log();
        send_frame(8'h5A, 1'b0, t0);
        idle(3);
        check("post_rst_count", 32'(pv_cyc.size()), 32'd1);
        if (pv_cyc.size() > 0) begin
            check("post_rst_cycle", 32'(pv_cyc[0] - t0), 32'(FL));
            check("post_rst_data",  32'(pv_dat[0]), 32'h5A);
        end

`ifdef S2P_PARITY_EN
        // Frame 0x07 with correct then wrong parity bit.
        clr_log();
        send_frame(8'h07, 1'b1, t0);
        idle(2);
        check("par_ok_count", 32'(pv_cyc.size()), 32'd1);
        if (pv_cyc.size() > 0) begin
            check("par_ok_cycle", 32'(pv_cyc[0] - t0), 32'd9);
            check("par_ok_data",  32'(pv_dat[0]), 32'h07);
            check("par_ok_perr",  32'(pv_perr[0]), 32'd0);
        end
        clr_log();
        send_frame(8'h07, 1'b0, t0);
        idle(2);
        check("par_bad_count", 32'(pv_cyc.size()), 32'd1);
        if (pv_cyc.size() > 0) begin
            check("par_bad_cycle", 32'(pv_cyc[0] - t0), 32'd9);
            check("par_bad_data",  32'(pv_dat[0]), 32'h07);
            check("par_bad_perr",  32'(pv_perr[0]), 32'd1);
        end
`endif

        idle(2);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/s2p_rx.md
Name: s2p_rx

Overview:
Serial-to-parallel receiver for the team's single-wire sync-framed link. It is the receiving end of the parallel-to-serial transmitter. One bit arrives per clk, MSB first, and sync is high together with the first (MSB) bit of each frame. The block reassembles each WIDTH-bit word and presents it on pdata with a one-cycle pvalid strobe. It sits between the serial link pins and the consuming datapath.

Parameters:
WIDTH, 8, data bits per frame; legal range 2..32.

Ports:
clk  input  1  clock; all sampling on rising edge.
reset_n  input  1  asynchronous, active-low reset.
sync  input  1  frame start; high only with the MSB bit.
sdata  input  1  serial data bit, valid every cycle while a frame is in flight.
pdata  output  WIDTH  last completed word; holds until the next completion.
pvalid  output  1  one-cycle strobe; pdata is new this cycle.
busy  output  1  high while a frame is being collected (SHIFT/PAR states).
frame_err  output  1  one-cycle strobe when a frame is aborted by an early sync.
parity_err  output  1  one-cycle strobe, coincident with pvalid; tied 0 unless PARITY_EN.

Behaviour:
- Reset values, all asynchronous:
  - state=IDLE, bit counter=0, shift register=0.
  - pdata=0, pvalid=0, busy=0, frame_err=0, parity_err=0.
- States:
  - IDLE: wait for sync.
  - SHIFT: collect data bits.
  - PAR: collect the parity bit; exists only with PARITY_EN.
- IDLE:
  - sync=1 captures sdata as bit WIDTH-1, sets counter=1, goes to SHIFT.
  - sync=0 keeps IDLE; sdata is ignored.
- SHIFT:
  - Each cycle, sdata shifts in as the next lower bit and counter increments.
  - The bit captured with counter=WIDTH-1 is bit 0.
  - On that edge, the full word is registered into pdata.
  - pvalid=1 for exactly the next cycle.
  - Without PARITY_EN, the next state is IDLE.
- Latency: pvalid is high in the cycle immediately after bit 0 is presented. A frame started by sync in cycle 0 gives pvalid in cycle WIDTH (cycle WIDTH+1 with parity).
- Early sync, i.e. sync=1 while in SHIFT or PAR:
  - The current frame is discarded; pdata is unchanged and there is no pvalid.
  - frame_err pulses for 1 cycle.
  - The sampled sdata becomes the MSB of a new frame, counter=1, state=SHIFT.
- Back-to-back frames:
  - sync may arrive in the cycle right after the final bit. That frame's pvalid and the new frame's MSB capture happen in the same cycle.
  - This is not an error, and there are no idle cycles between frames.
- busy is registered and high in every cycle the state is SHIFT or PAR.
- Output strobes:
  - pvalid and frame_err are never high in the same cycle.
  - Every strobe is exactly 1 cycle wide.
- Counter width is $clog2(WIDTH+1); it never exceeds WIDTH and wraps to 0 on returning to IDLE.
- Reset asserted mid-frame clears everything immediately. The partial word is lost, with no pvalid and no frame_err.
- sdata is ignored in IDLE when sync=0. sync=1 in IDLE is always a legal frame start.

Optional Feature:
S2P_PARITY_EN:
- Defined:
  - After bit 0, the FSM enters PAR and samples one even-parity bit, so the XOR of the WIDTH data bits and the parity bit must be 0.
  - On that edge, pdata is updated and pvalid pulses; parity_err pulses with pvalid if the check fails.
  - pdata is delivered even when parity fails.
  - Early sync in PAR is handled as in SHIFT.
- Undefined: there is no PAR state, parity_err is constant 0, and frame length is WIDTH.

Decomposition:
- Package s2p_pkg holds:
  - typedef enum state_t {IDLE, SHIFT, PAR}.
  - Function cnt_w(WIDTH) returning $clog2(WIDTH+1).
  - The even-parity function shared with the transmitter side.
- One sub-module, s2p_shift_reg: a WIDTH-bit MSB-first shift register with load-first-bit, shift, and clear controls. The FSM and counter stay in s2p_rx.

Test Plan:
- Single frame, WIDTH=8, no parity:
  - Stimulus: sync=1 with sdata=1 in cycle 0, then bits 0,1,0,0,1,0,1 (frame 0xA5).
  - Response: pvalid=1 in cycle 8 only; pdata=0xA5; busy high in cycles 1-8.
- Back-to-back frames 0x3C then 0xFF, second sync in cycle 8:
  - Response: pvalid in cycles 8 and 16.
  - pdata=0x3C, then 0xFF.
  - No frame_err.
- Early sync in cycle 4 of a frame:
  - Response: frame_err=1 in cycle 5 and no pvalid for the aborted frame.
  - The new frame 0x81 completes with pvalid in cycle 12 and pdata=0x81.
- reset_n low in cycle 3 of a frame:
  - Response: all outputs 0 immediately.
  - No pvalid follows.
  - Next frame 0x5A is received correctly.
- With S2P_PARITY_EN, frame 0x07:
  - Parity bit 1: pvalid in cycle 9, pdata=0x07, parity_err=0.
  - Parity bit 0: same pvalid, parity_err=1.
- Idle noise: sdata toggling with sync=0 for 20 cycles -> no pvalid, busy=0, pdata stays 0.
